lc3_mem_arbiter: RTL and testbench
==================================

Name: lc3_mem_arbiter

Overview:
- Shares the single LC-3 memory port (address, dataToMemory, writeEnable, dataFromMemory) between two requesters: instruction fetch (IF, read-only) and load/store (LS, read/write).
- Sits between the processor core and memory, so fetch and data accesses go through one port instead of the core muxing `address` internally.
- Each request is one transaction: grant, memory access with fixed read latency, then a one-cycle ack carrying read data.
- Ties are arbitrated round-robin.

Parameters:
- DATA_W, 16, memory word width.
- ADDR_W, 16, memory address width.
- MEM_LAT, 1, cycles from address presented to dataFromMemory valid; legal range 1..7.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request, level; held until if_ack.
- if_addr  in  ADDR_W  fetch address; stable while if_req is high.
- if_gnt  out  1  one-cycle pulse: fetch transaction issued.
- if_ack  out  1  one-cycle pulse: fetch done, if_rdata valid.
- if_rdata  out  DATA_W  fetch read data; holds until the next fetch ack.
- ls_req  in  1  load/store request, level; held until ls_ack.
- ls_we  in  1  1 = store, 0 = load.
- ls_addr  in  ADDR_W  load/store address.
- ls_wdata  in  DATA_W  store data.
- ls_gnt  out  1  one-cycle pulse: load/store transaction issued.
- ls_ack  out  1  one-cycle pulse: load/store done; ls_rdata valid for loads.
- ls_rdata  out  DATA_W  load data; holds until the next load ack.
- address  out  ADDR_W  memory address.
- dataToMemory  out  DATA_W  memory write data.
- writeEnable  out  1  memory write strobe.
- dataFromMemory  in  DATA_W  memory read data.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on `reset`.
- Reset values:
  - All outputs 0.
  - state = IDLE, wait counter = 0.
  - last_owner = LS, so IF wins the first tie.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Samples the two requests.
  - Only one req high: that port wins.
  - Both high: the port that is not last_owner wins.
  - Win: latch owner, address and write data/we (IF is always a read), then go to ISSUE.
  - Neither high: stay in IDLE.
- ISSUE, one cycle:
  - address = latched address; gnt of owner = 1; last_owner <= owner.
  - Store: dataToMemory = ls_wdata and writeEnable = 1 for this cycle only; next state DONE.
  - Read: writeEnable = 0; counter <= MEM_LAT; next state WAIT.
- WAIT, exactly MEM_LAT cycles:
  - address held; counter decrements.
  - In the last WAIT cycle (counter == 1), capture dataFromMemory into the owner's rdata register; next state DONE.
- DONE, one cycle: owner's ack = 1; next state IDLE.
- Latency, with T = IDLE cycle in which the request is sampled:
  - Read: gnt at T+1, ack at T+2+MEM_LAT.
  - Write: gnt at T+1, ack at T+2.
- Requester rule: req must be low in the cycle after ack unless a new transaction is intended. Because DONE is followed by IDLE, a registered requester can drop req in time.
- Outside ISSUE: writeEnable = 0; address and dataToMemory hold their last values.
- Boundary cases:
  - req dropped mid-transaction: ignored; the transaction completes and ack still pulses.
  - req rising while busy: waits; it is sampled in the next IDLE.
  - Both requesters continuously requesting: grants alternate IF, LS, IF, ... Neither waits more than one transaction.
  - Input changes after the IDLE sample: no effect on the current transaction.
  - Reset asserted mid-transaction: aborts at that edge with no ack; writeEnable low from the next cycle; IF wins the next tie.
  - gnt and ack never assert for both ports in the same cycle.

Decomposition:
- Shared package lc3_mem_pkg:
  - enum arb_state_t {IDLE, ISSUE, WAIT, DONE};
  - enum port_t {PORT_IF, PORT_LS};
  - localparam MAX_MEM_LAT = 7.
- Optional sub-module lc3_rr_pick2: two requests plus last_owner in, winner and valid out; purely combinational. The FSM, latches and output registers stay in lc3_mem_arbiter.

Test Plan:
- Reset, then idle 5 cycles -> all outputs 0, busy 0, writeEnable never high.
- Single fetch: if_req at T with if_addr=0x0003, memory returns 0x1234 (MEM_LAT=1) -> address=0x0003 from T+1, if_gnt at T+1, if_ack at T+3, if_rdata=0x1234; ls outputs stay 0.
- Store: ls_req/ls_we=1, ls_addr=0x0040, ls_wdata=0xBEEF at T -> writeEnable=1 only at T+1 with address=0x0040 and dataToMemory=0xBEEF; ls_ack at T+2; ls_rdata unchanged.
- Tie after reset: both req at T (IF addr 0x0010, LS load addr 0x0020) -> IF granted first (if_ack T+3); LS issued at T+5 (ls_gnt), ls_ack at T+7; repeat both -> IF next.
- MEM_LAT=3, load from 0x0100 returning 0x00FF -> ls_ack at T+5, ls_rdata=0x00FF; dataFromMemory garbage in earlier WAIT cycles is not captured.
- Reset asserted in WAIT of a fetch -> no if_ack, busy=0 next cycle; a subsequent tie is won by IF.

Source files
------------

// File: rtl/lc3_mem_pkg.sv
// Shared types and limits for the LC-3 memory port arbiter.
//   arb_state_t : arbiter FSM states
//   port_t      : requester identity (instruction fetch / load-store)
//   MAX_MEM_LAT : largest supported memory read latency
//   CNT_W       : width of the read-latency wait counter
package lc3_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } arb_state_t;

    typedef enum logic {
        PORT_IF,
        PORT_LS
    } port_t;

    localparam int unsigned MAX_MEM_LAT = 7;
    localparam int unsigned CNT_W       = 3;

endpackage

// File: rtl/lc3_mem_arbiter_rr_pick2.sv
// Two-way round-robin picker (purely combinational).
//   i_req_if   : fetch request
//   i_req_ls   : load/store request
//   i_last_ls  : 1 when load/store owned the previous transaction
//   o_valid_c  : at least one request present
//   o_win_ls_c : 1 = load/store wins, 0 = fetch wins
module lc3_rr_pick2 (
    input  logic i_req_if,
    input  logic i_req_ls,
    input  logic i_last_ls,
    output logic o_valid_c,
    output logic o_win_ls_c
);

    // On a tie the port that did not own the last transaction wins.
    always_comb begin
        o_valid_c  = i_req_if | i_req_ls;
        o_win_ls_c = i_req_ls;
        if (i_req_if && i_req_ls) begin
            o_win_ls_c = ~i_last_ls;
        end
    end

endmodule

// File: rtl/lc3_mem_arbiter.sv
// Shares the single LC-3 memory port between instruction fetch (read-only)
// and load/store (read/write). One transaction per request:
// grant -> memory access with fixed read latency -> one-cycle ack with data.
//   clk, reset               : clock, synchronous active-high reset
//   if_req/if_addr           : fetch request (level) and address
//   if_gnt/if_ack/if_rdata   : fetch issue pulse, done pulse, read data
//   ls_req/ls_we/ls_addr/ls_wdata : load/store request, store flag, address, data
//   ls_gnt/ls_ack/ls_rdata   : load/store issue pulse, done pulse, load data
//   address/dataToMemory/writeEnable/dataFromMemory : memory port
//   busy                     : arbiter not in IDLE
// MEM_LAT must lie in 1..MAX_MEM_LAT.
module lc3_mem_arbiter
    import lc3_mem_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_ack,
    output logic [DATA_W-1:0] ls_rdata,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] dataToMemory,
    output logic              writeEnable,
    input  logic [DATA_W-1:0] dataFromMemory,
    output logic              busy
);

    arb_state_t        r_state,  w_state;
    logic [CNT_W-1:0]  r_cnt,    w_cnt;
    port_t             r_owner,  w_owner;
    port_t             r_last,   w_last;
    logic              r_we,     w_we;
    logic [ADDR_W-1:0] r_address, w_address;
    logic [DATA_W-1:0] r_dtm,    w_dtm;
    logic [DATA_W-1:0] r_if_rdata, w_if_rdata;
    logic [DATA_W-1:0] r_ls_rdata, w_ls_rdata;
    logic              r_wen,    w_wen;
    logic              r_if_gnt, w_if_gnt;
    logic              r_ls_gnt, w_ls_gnt;
    logic              r_if_ack, w_if_ack;
    logic              r_ls_ack, w_ls_ack;
    logic              r_busy,   w_busy;
    logic              w_pick_valid;
    logic              w_pick_ls;

    lc3_rr_pick2 u_pick (
        .i_req_if   (if_req),
        .i_req_ls   (ls_req),
        .i_last_ls  (r_last == PORT_LS),
        .o_valid_c  (w_pick_valid),
        .o_win_ls_c (w_pick_ls)
    );

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_owner    <= PORT_IF;
            r_last     <= PORT_LS;
            r_we       <= 1'b0;
            r_address  <= '0;
            r_dtm      <= '0;
            r_if_rdata <= '0;
            r_ls_rdata <= '0;
            r_wen      <= 1'b0;
            r_if_gnt   <= 1'b0;
            r_ls_gnt   <= 1'b0;
            r_if_ack   <= 1'b0;
            r_ls_ack   <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_owner    <= w_owner;
            r_last     <= w_last;
            r_we       <= w_we;
            r_address  <= w_address;
            r_dtm      <= w_dtm;
            r_if_rdata <= w_if_rdata;
            r_ls_rdata <= w_ls_rdata;
            r_wen      <= w_wen;
            r_if_gnt   <= w_if_gnt;
            r_ls_gnt   <= w_ls_gnt;
            r_if_ack   <= w_if_ack;
            r_ls_ack   <= w_ls_ack;
            r_busy     <= w_busy;
        end
    end

    // Next state plus next values of the output registers; pulses are
    // computed one cycle early so they appear in the state they belong to.
    always_comb begin
        w_state    = r_state;
        w_cnt      = r_cnt;
        w_owner    = r_owner;
        w_last     = r_last;
        w_we       = r_we;
        w_address  = r_address;
        w_dtm      = r_dtm;
        w_if_rdata = r_if_rdata;
        w_ls_rdata = r_ls_rdata;
        w_wen      = 1'b0;
        w_if_gnt   = 1'b0;
        w_ls_gnt   = 1'b0;
        w_if_ack   = 1'b0;
        w_ls_ack   = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_state = ISSUE;
                    if (w_pick_ls) begin
                        w_owner   = PORT_LS;
                        w_address = ls_addr;
                        w_we      = ls_we;
                        w_ls_gnt  = 1'b1;
                        if (ls_we) begin
                            w_dtm = ls_wdata;
                            w_wen = 1'b1;
                        end
                    end else begin
                        w_owner   = PORT_IF;
                        w_address = if_addr;
                        w_we      = 1'b0;
                        w_if_gnt  = 1'b1;
                    end
                end
            end
            ISSUE: begin
                w_last = r_owner;
                if (r_we) begin
                    // Only load/store can write.
                    w_state  = DONE;
                    w_ls_ack = 1'b1;
                end else begin
                    w_state = WAIT;
                    w_cnt   = CNT_W'(MEM_LAT);
                end
            end
            WAIT: begin
                w_cnt = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_state = DONE;
                    if (r_owner == PORT_LS) begin
                        w_ls_rdata = dataFromMemory;
                        w_ls_ack   = 1'b1;
                    end else begin
                        w_if_rdata = dataFromMemory;
                        w_if_ack   = 1'b1;
                    end
                end
            end
            DONE: begin
                w_state = IDLE;
            end
            default: begin
                w_state = IDLE;
            end
        endcase

        w_busy = (w_state != IDLE);
    end

    assign if_gnt       = r_if_gnt;
    assign if_ack       = r_if_ack;
    assign if_rdata     = r_if_rdata;
    assign ls_gnt       = r_ls_gnt;
    assign ls_ack       = r_ls_ack;
    assign ls_rdata     = r_ls_rdata;
    assign address      = r_address;
    assign dataToMemory = r_dtm;
    assign writeEnable  = r_wen;
    assign busy         = r_busy;

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Bench for lc3_mem_arbiter: two instances (MEM_LAT 1 and 3), each with its
// own behavioural memory. A transaction-level reference model predicts the
// round-robin winner, the grant/ack timeline and the data of every request.
module tb_lc3_mem_arbiter;

    localparam int unsigned NDUT = 2;
    localparam int unsigned DW   = 16;
    localparam int unsigned AW   = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NDUT-1:0]         reset;
    logic [NDUT-1:0]         if_req, if_gnt, if_ack;
    logic [NDUT-1:0][AW-1:0] if_addr;
    logic [NDUT-1:0][DW-1:0] if_rdata;
    logic [NDUT-1:0]         ls_req, ls_we, ls_gnt, ls_ack;
    logic [NDUT-1:0][AW-1:0] ls_addr;
    logic [NDUT-1:0][DW-1:0] ls_wdata, ls_rdata;
    logic [NDUT-1:0][AW-1:0] address;
    logic [NDUT-1:0][DW-1:0] dataToMemory, dataFromMemory;
    logic [NDUT-1:0]         writeEnable, busy;

    // Contents of never-written memory words.
    function automatic logic [DW-1:0] mem_init(input logic [9:0] a);
        return DW'({6'd0, a} * 16'h9E37) ^ 16'hC3A5;
    endfunction

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int unsigned LAT = (g == 0) ? 1 : 3;
        bit [AW-1:0] apipe [LAT];
        bit [DW-1:0] mem   [1024];
        bit          wr    [1024];

        lc3_mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MEM_LAT(LAT)) u_dut (
            .clk            (clk),
            .reset          (reset[g]),
            .if_req         (if_req[g]),
            .if_addr        (if_addr[g]),
            .if_gnt         (if_gnt[g]),
            .if_ack         (if_ack[g]),
            .if_rdata       (if_rdata[g]),
            .ls_req         (ls_req[g]),
            .ls_we          (ls_we[g]),
            .ls_addr        (ls_addr[g]),
            .ls_wdata       (ls_wdata[g]),
            .ls_gnt         (ls_gnt[g]),
            .ls_ack         (ls_ack[g]),
            .ls_rdata       (ls_rdata[g]),
            .address        (address[g]),
            .dataToMemory   (dataToMemory[g]),
            .writeEnable    (writeEnable[g]),
            .dataFromMemory (dataFromMemory[g]),
            .busy           (busy[g])
        );

        // Memory: read data appears LAT cycles after the address.
        always_ff @(posedge clk) begin
            apipe[0] <= address[g];
            for (int i = 1; i < int'(LAT); i++) apipe[i] <= apipe[i-1];
            if (writeEnable[g]) begin
                mem[address[g][9:0]] <= dataToMemory[g];
                wr[address[g][9:0]]  <= 1'b1;
            end
        end
        assign dataFromMemory[g] = wr[apipe[LAT-1][9:0]] ? mem[apipe[LAT-1][9:0]]
                                                         : mem_init(apipe[LAT-1][9:0]);
    end

    int unsigned   n_cmp = 0;
    int unsigned   n_bad = 0;
    int unsigned   lat        [NDUT];
    bit            m_last_ls  [NDUT];
    logic [DW-1:0] m_if_rdata [NDUT];
    logic [DW-1:0] m_ls_rdata [NDUT];
    logic [DW-1:0] m_dtm      [NDUT];
    logic [AW-1:0] m_addr     [NDUT];
    bit   [DW-1:0] xmem       [NDUT][1024];
    bit            xwr        [NDUT][1024];

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s dut%0d: observed %0h expected %0h", tag, d, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] m_read(input int d, input logic [AW-1:0] a);
        return xwr[d][a[9:0]] ? xmem[d][a[9:0]] : mem_init(a[9:0]);
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        return ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 31));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic raise_if(input int d, input logic [AW-1:0] a);
        if_req[d]  = 1'b1;
        if_addr[d] = a;
    endtask

    task automatic raise_ls(input int d, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        ls_req[d]   = 1'b1;
        ls_we[d]    = w;
        ls_addr[d]  = a;
        ls_wdata[d] = wd;
    endtask

    task automatic chk_idle(input int d, input string tag);
        chk({tag, "_busy"},   d, 32'(busy[d]), 0);
        chk({tag, "_pulses"}, d, 32'({if_gnt[d], if_ack[d], ls_gnt[d], ls_ack[d], writeEnable[d]}), 0);
        chk({tag, "_addr"},   d, 32'(address[d]), 32'(m_addr[d]));
        chk({tag, "_dtm"},    d, 32'(dataToMemory[d]), 32'(m_dtm[d]));
        chk({tag, "_ifrd"},   d, 32'(if_rdata[d]), 32'(m_if_rdata[d]));
        chk({tag, "_lsrd"},   d, 32'(ls_rdata[d]), 32'(m_ls_rdata[d]));
    endtask

    task automatic model_reset(input int d);
        m_last_ls[d]  = 1'b1;
        m_if_rdata[d] = '0;
        m_ls_rdata[d] = '0;
        m_dtm[d]      = '0;
        m_addr[d]     = '0;
    endtask

    task automatic do_reset(input int d);
        reset[d]  = 1'b1;
        if_req[d] = 1'b0;
        ls_req[d] = 1'b0;
        step();
        reset[d] = 1'b0;
        model_reset(d);
        chk_idle(d, "reset");
    endtask

    // Called in an IDLE cycle with requests already driven; serves every
    // pending request and returns in the IDLE cycle after the last ack.
    task automatic serve(input int d, input int reissue, input bit allow_late);
        int rounds = 0;
        int left   = reissue;
        while (if_req[d] || ls_req[d]) begin
            bit            win_ls;
            bit            we;
            logic [AW-1:0] a;
            logic [DW-1:0] wd;
            int            dur;
            rounds++;
            if (rounds > 12) begin
                n_cmp++;
                n_bad++;
                $error("FAIL serve_budget dut%0d: observed %0d rounds expected at most 12", d, rounds);
                if_req[d] = 1'b0;
                ls_req[d] = 1'b0;
                break;
            end
            chk("sample_busy", d, 32'(busy[d]), 0);
            win_ls = (if_req[d] && ls_req[d]) ? !m_last_ls[d] : ls_req[d];
            we     = win_ls && ls_we[d];
            a      = win_ls ? ls_addr[d] : if_addr[d];
            wd     = ls_wdata[d];
            dur    = we ? 2 : 2 + int'(lat[d]);
            for (int k = 1; k <= dur; k++) begin
                step();
                m_addr[d] = a;
                if (we && k == 1) m_dtm[d] = wd;
                if (!we && k == dur) begin
                    if (win_ls) m_ls_rdata[d] = m_read(d, a);
                    else        m_if_rdata[d] = m_read(d, a);
                end
                chk("if_gnt",  d, 32'(if_gnt[d]), 32'(!win_ls && k == 1));
                chk("ls_gnt",  d, 32'(ls_gnt[d]), 32'(win_ls && k == 1));
                chk("if_ack",  d, 32'(if_ack[d]), 32'(!win_ls && k == dur));
                chk("ls_ack",  d, 32'(ls_ack[d]), 32'(win_ls && k == dur));
                chk("busy",    d, 32'(busy[d]), 1);
                chk("wen",     d, 32'(writeEnable[d]), 32'(we && k == 1));
                chk("address", d, 32'(address[d]), 32'(m_addr[d]));
                chk("dtm",     d, 32'(dataToMemory[d]), 32'(m_dtm[d]));
                chk("if_rdata", d, 32'(if_rdata[d]), 32'(m_if_rdata[d]));
                chk("ls_rdata", d, 32'(ls_rdata[d]), 32'(m_ls_rdata[d]));
                if (k == 1) begin
                    // Winner inputs change after the sample; may even drop req.
                    if (win_ls) raise_ls(d, 1'($urandom_range(0, 1)), rand_addr(), DW'($urandom));
                    else        raise_if(d, rand_addr());
                    if ($urandom_range(0, 3) == 0) begin
                        if (win_ls) ls_req[d] = 1'b0;
                        else        if_req[d] = 1'b0;
                    end
                    if (allow_late && $urandom_range(0, 1) == 0) begin
                        if (win_ls && !if_req[d]) raise_if(d, rand_addr());
                        if (!win_ls && !ls_req[d])
                            raise_ls(d, 1'($urandom_range(0, 1)), rand_addr(), DW'($urandom));
                        allow_late = 1'b0;
                    end
                end
                if (k == dur) begin
                    if (left > 0) begin
                        left--;
                        if (win_ls) raise_ls(d, 1'($urandom_range(0, 1)), rand_addr(), DW'($urandom));
                        else        raise_if(d, rand_addr());
                    end else begin
                        if (win_ls) ls_req[d] = 1'b0;
                        else        if_req[d] = 1'b0;
                    end
                end
            end
            m_last_ls[d] = win_ls;
            if (we) begin
                xmem[d][a[9:0]] = wd;
                xwr[d][a[9:0]]  = 1'b1;
            end
            step();
        end
        chk_idle(d, "after");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        lat[0]   = 1;
        lat[1]   = 3;
        reset    = '1;
        if_req   = '0;
        ls_req   = '0;
        ls_we    = '0;
        if_addr  = '0;
        ls_addr  = '0;
        ls_wdata = '0;
        for (int d = 0; d < int'(NDUT); d++) model_reset(d);
        step();
        step();
        for (int d = 0; d < int'(NDUT); d++) do_reset(d);

        // Idle after reset: everything stays zero.
        repeat (5) begin
            step();
            for (int d = 0; d < int'(NDUT); d++) chk_idle(d, "idle");
        end

        // Single fetch of a word preloaded by a store.
        raise_ls(0, 1'b1, 16'h0003, 16'h1234);
        serve(0, 0, 1'b0);
        raise_if(0, 16'h0003);
        serve(0, 0, 1'b0);
        chk("fetch_data", 0, 32'(if_rdata[0]), 32'h1234);

        // Store: ls_rdata untouched.
        raise_ls(0, 1'b1, 16'h0040, 16'hBEEF);
        serve(0, 0, 1'b0);
        chk("store_dtm", 0, 32'(dataToMemory[0]), 32'hBEEF);

        // Tie right after reset goes to fetch, then alternates.
        do_reset(0);
        raise_if(0, 16'h0010);
        raise_ls(0, 1'b0, 16'h0020, 16'h0000);
        serve(0, 0, 1'b0);
        raise_if(0, 16'h0011);
        raise_ls(0, 1'b0, 16'h0021, 16'h0000);
        serve(0, 0, 1'b0);

        // MEM_LAT=3: data only captured in the last wait cycle.
        raise_ls(1, 1'b1, 16'h0100, 16'h00FF);
        serve(1, 0, 1'b0);
        raise_ls(1, 1'b0, 16'h0200, 16'h0000);
        serve(1, 0, 1'b0);
        raise_ls(1, 1'b0, 16'h0100, 16'h0000);
        serve(1, 0, 1'b0);
        chk("lat3_load", 1, 32'(ls_rdata[1]), 32'h00FF);

        // Reset in the wait phase of a fetch aborts it without an ack.
        raise_if(0, 16'h0005);
        step();
        chk("abort_gnt", 0, 32'(if_gnt[0]), 1);
        step();
        chk("abort_wait_busy", 0, 32'(busy[0]), 1);
        chk("abort_wait_ack", 0, 32'(if_ack[0]), 0);
        reset[0]  = 1'b1;
        if_req[0] = 1'b0;
        step();
        reset[0] = 1'b0;
        model_reset(0);
        chk_idle(0, "abort");
        step();
        chk_idle(0, "abort2");
        raise_if(0, 16'h0007);
        raise_ls(0, 1'b1, 16'h0008, 16'h5555);
        serve(0, 0, 1'b0);

        // Randomised traffic on both latencies.
        for (int d = 0; d < int'(NDUT); d++) begin
            for (int i = 0; i < 120; i++) begin
                int p;
                p = int'($urandom_range(0, 3));
                if (p != 1) raise_if(d, rand_addr());
                if (p != 0) raise_ls(d, 1'($urandom_range(0, 1)), rand_addr(), DW'($urandom));
                serve(d, (p == 3) ? int'($urandom_range(1, 4)) : 0, 1'($urandom_range(0, 1)));
                repeat ($urandom_range(0, 2)) begin
                    step();
                    chk_idle(d, "gap");
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
